simd_wb_queue: RTL and testbench
================================

Name: simd_wb_queue

Overview:
- Sits directly downstream of the SIMD integer/logic execute unit.
- Tracks destination tags for issued ops through a delay line matched to the unit's fixed latency and captures the unit's 68-bit result when it emerges.
- Buffers tag+result in a small FIFO for the shared writeback port.
- Issues credit-based back-pressure so the unit never produces a result with no slot free.

Parameters:
- LAT, 2: execute-unit latency in cycles, from the issue strobe to a valid result. Legal range 1..4.
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- TAGW, 9: destination tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low. Clears all state.
- iss_en  in  1  op issued to the execute unit this cycle. Ignored while iss_stall=1.
- iss_tag  in  TAGW  destination tag of the issued op.
- flush  in  1  synchronous kill of all in-flight and queued ops.
- res_in  in  68  execute-unit result: bits [67:66] ptype, [64:33] high word, [31:0] low word. May be Z when invalid; sample it only when the delay-line head is valid.
- iss_stall  out  1  no credit available; the issuer must not assert iss_en.
- wb_valid  out  1  FIFO head valid.
- wb_tag  out  TAGW  FIFO head tag.
- wb_data  out  68  FIFO head result.
- wb_ready  in  1  writeback port accepts the head this cycle.
- occ  out  $clog2(DEPTH)+1  number of FIFO entries occupied.

Behaviour:
- Reset values (rst=0, asynchronous):
  - delay-line valids = 0
  - FIFO read pointer, write pointer and count = 0
  - wb_valid=0, wb_tag=0, wb_data=0, occ=0
  - iss_stall=0
  - credit = DEPTH
- Reset mid-operation drops all in-flight and queued ops; no writeback occurs afterwards.
- Delay line:
  - LAT stages of {valid, tag}.
  - Stage 0 loads {iss_en & ~iss_stall, iss_tag}.
  - The head is stage LAT-1.
  - An op issued at posedge N is captured at posedge N+LAT together with res_in.
- Capture: when the head is valid, write {tag, res_in} to the FIFO at the write pointer. Capture does not depend on ptype.
- Credit accounting:
  - credit = DEPTH − occupancy − in-flight valids.
  - Decrement on accepted issue; increment on pop.
  - Same-cycle issue and pop leave credit unchanged.
  - iss_stall = (credit == 0), registered from next-state credit so it is glitch-free.
  - The FIFO therefore never overflows.
  - Overflow is a design error: the bench assertion "capture while count==DEPTH" must never fire.
- Pop:
  - A pop occurs when wb_valid & wb_ready.
  - The read pointer advances and the next head appears the following cycle.
  - wb_* outputs are driven combinationally from FIFO storage at the read pointer.
  - wb_data holds stable while wb_valid=1 and wb_ready=0.
- Simultaneous capture and pop:
  - Both take effect and count is unchanged.
  - If count==0, the captured entry is not bypassed; it appears on wb_* the next cycle. Minimum capture-to-wb_valid latency is 1.
- Pointers wrap modulo DEPTH. count runs 0..DEPTH. occ = count.
- flush=1 at posedge:
  - all delay-line valids, count and pointers cleared
  - credit = DEPTH
  - iss_en in the same cycle is discarded
  - wb_ready in the same cycle is ignored
  - wb_valid=0 the next cycle
- Full FIFO with wb_ready held low: credit reaches 0 and iss_stall=1; in-flight ops still land because their credit was reserved at issue.

Test Plan:
- Single op: release rst, issue tag=0x05 at cycle 10 with wb_ready=1, res_in=68'h0_1234_5678_9ABC_DEF0 at cycle 12 (LAT=2). Expect wb_valid=1 at cycle 13 with wb_tag=0x05 and wb_data equal to the driven value; occ returns to 0 at cycle 14.
- Back-pressure: hold wb_ready=0 and issue on 6 consecutive cycles. Expect iss_stall=1 once 4 ops are accepted, exactly 4 entries captured with occ=4, tags in issue order; raising wb_ready drains one entry per cycle.
- Streaming: wb_ready=1, issue every cycle for 20 cycles. Expect iss_stall to stay 0, results emerge in order at 1 per cycle, and occ never exceeds 1.
- Flush: with 2 ops in flight and 2 queued, assert flush for 1 cycle together with iss_en. Expect wb_valid=0 and occ=0 next cycle, no capture at the later res_in cycles, and credit restored to 4 (iss_stall=0).
- Async reset: drop rst mid-stream between clock edges. Expect wb_valid=0 and iss_stall=0 immediately without waiting for a clock edge, and no stale writeback after rst rises.
- Wrap and sign: push and pop 9 entries so the pointers wrap twice, using alternating ptype values and res_in bit 67 set. Expect every entry to return bit-exact in order.

Source files
------------

// File: rtl/simd_wb_queue.sv
// Writeback queue behind the SIMD execute unit: a tag delay line matched to the unit
// latency, a small result FIFO and credit-based issue back-pressure.
module simd_wb_queue #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAGW  = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_en,
  input  logic [TAGW-1:0]            iss_tag,
  input  logic                       flush,
  input  logic [67:0]                res_in,
  output logic                       iss_stall,
  output logic                       wb_valid,
  output logic [TAGW-1:0]            wb_tag,
  output logic [67:0]                wb_data,
  input  logic                       wb_ready,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TAGW + 68;

  logic [LAT-1:0]           vld_q, vld_d;
  logic [LAT-1:0][TAGW-1:0] tag_q, tag_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [CW-1:0]            credit_q, credit_d;
  logic                     iss_stall_q, iss_stall_d;
  logic [EW-1:0]            mem_q [DEPTH];
  logic [EW-1:0]            head;

  logic issue_ok, capture, pop;

  assign issue_ok = iss_en & ~iss_stall_q & ~flush;
  assign capture  = vld_q[LAT-1] & ~flush;
  assign pop      = wb_valid & wb_ready & ~flush;

  always_comb begin
    vld_d[0] = issue_ok;
    tag_d[0] = iss_tag;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    wr_ptr_d = wr_ptr_q + PW'(capture);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(capture) - CW'(pop);
    // Credit is reserved at issue, so an in-flight op always has a slot waiting.
    credit_d = credit_q - CW'(issue_ok) + CW'(pop);
    if (flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      credit_d = CW'(DEPTH);
    end
    iss_stall_d = (credit_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= '0;
      tag_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      credit_q    <= CW'(DEPTH);
      iss_stall_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      credit_q    <= credit_d;
      iss_stall_q <= iss_stall_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= {tag_q[LAT-1], res_in};
  end

  assign head      = mem_q[rd_ptr_q];
  assign wb_valid  = (count_q != '0);
  assign wb_tag    = wb_valid ? head[EW-1:68] : '0;
  assign wb_data   = wb_valid ? head[67:0] : '0;
  assign iss_stall = iss_stall_q;
  assign occ       = count_q;

endmodule

// File: tb/tb_simd_wb_queue.sv
// Directed self-checking bench for simd_wb_queue (LAT=2, DEPTH=4, TAGW=9).
module tb_simd_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_en;
  logic [8:0]  iss_tag;
  logic        flush;
  logic [67:0] res_in;
  logic        iss_stall;
  logic        wb_valid;
  logic [8:0]  wb_tag;
  logic [67:0] wb_data;
  logic        wb_ready;
  logic [2:0]  occ;

  logic        auto_res;
  logic [67:0] res_drv;
  logic [8:0]  hist0, hist1;

  int compareCount  = 0;
  int mismatchCount = 0;

  localparam logic [67:0] JUNK   = {4'hF, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [67:0] SINGLE = 68'h0_1234_5678_9ABC_DEF0;

  simd_wb_queue #(.LAT(2), .DEPTH(4), .TAGW(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_en    (iss_en),
    .iss_tag   (iss_tag),
    .flush     (flush),
    .res_in    (res_in),
    .iss_stall (iss_stall),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  // Result pattern per tag: bit 67 always set, ptype alternates with tag[0].
  function automatic logic [67:0] mkres(input logic [8:0] t);
    return {1'b1, t[0], 1'b1, {23'h7A5A5A, t}, 1'b1, ~{23'h0, t}};
  endfunction

  // The unit's result for the tag driven two edges ago, as the real unit would produce.
  always @(posedge clk) begin
    hist0 <= iss_tag;
    hist1 <= hist0;
  end
  assign res_in = auto_res ? mkres(hist1) : res_drv;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [8:0] tag, input logic ready, input logic fl);
    iss_en   = en;
    iss_tag  = tag;
    wb_ready = ready;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A capture into a full FIFO must never be possible.
  always @(negedge clk) begin
    if (rst)
      checkOutput("overflow_guard", 128'(dut.vld_q[1] && (dut.count_q == 3'd4) && !flush), 128'd0);
  end

  task automatic runStream(input logic [8:0] base, input int n);
    logic [8:0] t;
    for (int k = 0; k < n + 2; k++) begin
      applyStimulus(k < n, 9'(base + 9'(k)), 1'b1, 1'b0);
      tick();
      checkOutput("stream_stall", 128'(iss_stall), 128'd0);
      checkOutput("stream_occ", 128'(occ), (k >= 2) ? 128'd1 : 128'd0);
      if (k >= 2) begin
        t = 9'(base + 9'(k - 2));
        checkOutput("stream_tag", 128'(wb_tag), 128'(t));
        checkOutput("stream_data", 128'(wb_data), 128'(mkres(t)));
      end
    end
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_drained", 128'(occ), 128'd0);
  endtask

  initial begin
    rst      = 1'b0;
    auto_res = 1'b1;
    res_drv  = '0;
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wb_valid", 128'(wb_valid), 128'd0);
    checkOutput("rst_stall", 128'(iss_stall), 128'd0);
    checkOutput("rst_occ", 128'(occ), 128'd0);
    checkOutput("rst_wb_tag", 128'(wb_tag), 128'd0);
    checkOutput("rst_wb_data", 128'(wb_data), 128'd0);
    rst = 1'b1;
    tick();
    tick();

    // Single op with an explicitly driven result; res_in is junk outside the capture cycle.
    auto_res = 1'b0;
    res_drv  = JUNK;
    applyStimulus(1'b1, 9'h005, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    tick();
    checkOutput("single_not_yet", 128'(wb_valid), 128'd0);
    res_drv = SINGLE;
    tick();
    res_drv = JUNK;
    checkOutput("single_valid", 128'(wb_valid), 128'd1);
    checkOutput("single_tag", 128'(wb_tag), 128'h005);
    checkOutput("single_data", 128'(wb_data), 128'(SINGLE));
    checkOutput("single_occ", 128'(occ), 128'd1);
    tick();
    checkOutput("single_popped_occ", 128'(occ), 128'd0);
    checkOutput("single_popped_valid", 128'(wb_valid), 128'd0);
    auto_res = 1'b1;

    // Back-pressure: only four of six issues are accepted.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 9'(9'h010 + 9'(i)), 1'b0, 1'b0);
      tick();
      checkOutput("bp_stall", 128'(iss_stall), (i >= 3) ? 128'd1 : 128'd0);
    end
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("bp_full_occ", 128'(occ), 128'd4);
    checkOutput("bp_head_tag", 128'(wb_tag), 128'h010);
    checkOutput("bp_head_data", 128'(wb_data), 128'(mkres(9'h010)));
    checkOutput("bp_still_stall", 128'(iss_stall), 128'd1);
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("bp_drain_occ", 128'(occ), 128'(4 - i));
      if (i < 4) begin
        checkOutput("bp_drain_tag", 128'(wb_tag), 128'(9'h010 + 9'(i)));
        checkOutput("bp_drain_data", 128'(wb_data), 128'(mkres(9'(9'h010 + 9'(i)))));
      end
      if (i == 1) checkOutput("bp_credit_back", 128'(iss_stall), 128'd0);
    end

    runStream(9'h040, 20);

    // Flush with two queued and two in flight, plus a same-cycle issue.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 9'(9'h060 + 9'(i)), 1'b0, 1'b0);
      tick();
    end
    checkOutput("flush_pre_occ", 128'(occ), 128'd2);
    checkOutput("flush_pre_stall", 128'(iss_stall), 128'd1);
    applyStimulus(1'b1, 9'h064, 1'b1, 1'b1);
    tick();
    checkOutput("flush_valid", 128'(wb_valid), 128'd0);
    checkOutput("flush_occ", 128'(occ), 128'd0);
    checkOutput("flush_stall", 128'(iss_stall), 128'd0);
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("flush_no_capture_occ", 128'(occ), 128'd0);
      checkOutput("flush_no_capture_valid", 128'(wb_valid), 128'd0);
    end

    // Asynchronous reset between edges while stalled with entries queued.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 9'(9'h0A0 + 9'(i)), 1'b0, 1'b0);
      tick();
    end
    checkOutput("arst_pre_occ", 128'(occ), 128'd3);
    checkOutput("arst_pre_stall", 128'(iss_stall), 128'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", 128'(wb_valid), 128'd0);
    checkOutput("arst_stall", 128'(iss_stall), 128'd0);
    checkOutput("arst_occ", 128'(occ), 128'd0);
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("arst_no_stale_valid", 128'(wb_valid), 128'd0);
      checkOutput("arst_no_stale_occ", 128'(occ), 128'd0);
    end

    // Nine entries through a four-deep FIFO wrap the pointers twice.
    runStream(9'h1A0, 9);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
